microwave_controller: RTL and testbench

- Microwave-oven front-panel controller with a digit keypad, start/stop/clear buttons and a door sensor.
- Shows an M:SS cook time on three 7-segment displays and counts it down once per second while driving the magnetron enable.
- Top-level control block, clocked from a slow 100 Hz system clock; it also contains the once-per-second prescaler.

---
 rtl/microwave_pkg.sv | 41 ++++
 rtl/seg7_decoder.sv | 30 +++
 rtl/microwave_controller.sv | 155 +++++++++++++++
 tb/tb_microwave_controller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// microwave_pkg
//   Shared types and constants for the microwave front-panel controller:
//   FSM state enum, BCD digit type, active-low 7-segment patterns
//   (bit0 = a .. bit6 = g) and small keypad helpers.
package microwave_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COOK   = 2'd1,
        PAUSED = 2'd2
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    function automatic logic is_onehot10(input logic [9:0] v);
        return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
    endfunction

    // Only meaningful for a one-hot input.
    function automatic bcd_t key_to_digit(input logic [9:0] key);
        bcd_t d;
        d = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (key[i]) d = bcd_t'(i);
        end
        return d;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder
//   Combinational BCD to active-low 7-segment decoder; 10..15 blank.
//   Ports:
//     digit_i  in  4  BCD digit
//     seg_o    out 7  segments, bit0 = a .. bit6 = g, active-low
module seg7_decoder
    import microwave_pkg::*;
(
    input  bcd_t       digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/microwave_controller.sv
// microwave_controller
//   Front-panel controller: keypad entry of an M:SS cook time, start/stop/
//   clear buttons, door interlock, once-per-second countdown and magnetron
//   enable. Synchronous active-high reset.
//   Ports:
//     clock         in   system clock (100 Hz nominal)
//     reset         in   synchronous reset, active-high
//     keypad        in   one-hot digit keys, bit n = digit n
//     startn/stopn/clearn in  buttons, active-low
//     door_closed   in   1 = door closed
//     sec_ones_seg/sec_tens_seg/mins_seg  out  active-low 7-segment displays
//     mag_on        out  magnetron enable, high only while cooking
//   Build option: LEADING_ZERO_BLANK_EN blanks the minutes display when
//   the minutes digit is 0.
//
//   state  | meaning
//   IDLE   | time entry allowed, magnetron off
//   COOK   | counting down once per second, magnetron on
//   PAUSED | time held, entry blocked, magnetron off
module microwave_controller
    import microwave_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] keypad,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    output logic [6:0] sec_ones_seg,
    output logic [6:0] sec_tens_seg,
    output logic [6:0] mins_seg,
    output logic       mag_on
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    state_e        state_q, state_d;
    bcd_t          mins_q, mins_d, tens_q, tens_d, ones_q, ones_d;
    bcd_t          dec_mins, dec_tens, dec_ones;
    logic [PW-1:0] presc_q, presc_d;
    logic [9:0]    key_prev_q;
    logic          key_hit, time_zero, start_ok, sec_tick, last_sec, cook_hold;

    // A key counts only on the transition from no key to exactly one key.
    assign key_hit   = (key_prev_q == 10'd0) && is_onehot10(keypad);
    assign time_zero = (mins_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
    assign start_ok  = !startn && door_closed && !time_zero;
    assign sec_tick  = (presc_q == PRESC_LAST);
    assign cook_hold = !stopn || !door_closed;

    // One-second decrement with BCD borrow; tens borrow reloads 5, so an
    // unvalidated tens digit above 5 simply counts down through its range.
    always_comb begin
        dec_mins = mins_q;
        dec_tens = tens_q;
        dec_ones = ones_q;
        if (ones_q != 4'd0) begin
            dec_ones = ones_q - 4'd1;
        end else begin
            dec_ones = 4'd9;
            if (tens_q != 4'd0) begin
                dec_tens = tens_q - 4'd1;
            end else begin
                dec_tens = 4'd5;
                dec_mins = mins_q - 4'd1;
            end
        end
    end

    assign last_sec = (dec_mins == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!clearn) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, PAUSED: if (start_ok) state_d = COOK;
                COOK: begin
                    if (cook_hold)                 state_d = PAUSED;
                    else if (sec_tick && last_sec) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        mag_on = (state_q == COOK);
    end

    // Time digits and prescaler; the prescaler only runs while cooking
    // continues and is zero everywhere else.
    always_comb begin
        mins_d  = mins_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        presc_d = '0;
        if (!clearn) begin
            mins_d = 4'd0;
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (state_q == COOK && !cook_hold) begin
            if (sec_tick) begin
                mins_d = dec_mins;
                tens_d = dec_tens;
                ones_d = dec_ones;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else if (state_q == IDLE && key_hit) begin
            mins_d = tens_q;
            tens_d = ones_q;
            ones_d = key_to_digit(keypad);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mins_q     <= 4'd0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            presc_q    <= '0;
            key_prev_q <= 10'd0;
        end else begin
            mins_q     <= mins_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            presc_q    <= presc_d;
            key_prev_q <= keypad;
        end
    end

    logic [6:0] mins_seg_raw;

    seg7_decoder u_dec_ones (.digit_i(ones_q), .seg_o(sec_ones_seg));
    seg7_decoder u_dec_tens (.digit_i(tens_q), .seg_o(sec_tens_seg));
    seg7_decoder u_dec_mins (.digit_i(mins_q), .seg_o(mins_seg_raw));

`ifdef LEADING_ZERO_BLANK_EN
    assign mins_seg = (mins_q == 4'd0) ? SEG_BLANK : mins_seg_raw;
`else
    assign mins_seg = mins_seg_raw;
`endif

endmodule

// File: tb/tb_microwave_controller.sv
module tb_microwave_controller;

    localparam int TPS = 100;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] keypad;
    logic       startn, stopn, clearn, door_closed;
    logic [6:0] sec_ones_seg, sec_tens_seg, mins_seg;
    logic       mag_on;

    int checks = 0;
    int errors = 0;

    // Reference model: time as minutes plus a two-digit seconds number.
    bit         m_cook, m_paused, lockstep;
    int         m_mins, m_sec, m_cnt;
    logic [9:0] m_prev;

    microwave_controller #(.TICKS_PER_SEC(TPS)) dut (
        .clock(clock), .reset(reset), .keypad(keypad),
        .startn(startn), .stopn(stopn), .clearn(clearn),
        .door_closed(door_closed),
        .sec_ones_seg(sec_ones_seg), .sec_tens_seg(sec_tens_seg),
        .mins_seg(mins_seg), .mag_on(mag_on)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg_exp(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] mins_exp(input int v);
`ifdef LEADING_ZERO_BLANK_EN
        if (v == 0) return 7'b1111111;
`endif
        return seg_exp(v);
    endfunction

    task automatic model_step();
        int  d;
        bit  newkey, was_idle;
        if (reset) begin
            m_cook = 0; m_paused = 0; m_mins = 0; m_sec = 0; m_cnt = 0; m_prev = '0;
            return;
        end
        newkey = (m_prev == 10'd0) && ($countones(keypad) == 1);
        if (!clearn) begin
            m_mins = 0; m_sec = 0; m_cook = 0; m_paused = 0; m_cnt = 0;
        end else if (m_cook) begin
            if (!stopn || !door_closed) begin
                m_cook = 0; m_paused = 1; m_cnt = 0;
            end else begin
                m_cnt++;
                if (m_cnt == TPS) begin
                    m_cnt = 0;
                    if (m_sec > 0) m_sec--;
                    else begin m_sec = 59; m_mins--; end
                    if (m_mins == 0 && m_sec == 0) m_cook = 0;
                end
            end
        end else begin
            was_idle = !m_paused;
            if (!startn && door_closed && (m_mins + m_sec) != 0) begin
                m_cook = 1; m_paused = 0; m_cnt = 0;
            end
            if (was_idle && newkey) begin
                d = 0;
                for (int i = 0; i < 10; i++) if (keypad[i]) d = i;
                m_mins = m_sec / 10;
                m_sec  = (m_sec % 10) * 10 + d;
            end
        end
        m_prev = keypad;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        model_step();
    endtask

    task automatic chk_time(input string tag, input int m, input int t, input int o);
        chk({tag, ".mins"}, mins_seg, mins_exp(m));
        chk({tag, ".tens"}, sec_tens_seg, seg_exp(t));
        chk({tag, ".ones"}, sec_ones_seg, seg_exp(o));
    endtask

    task automatic press(input int d, input int hold);
        keypad = 10'd1 << d;
        repeat (hold) tick();
        keypad = '0;
        repeat (2) tick();
    endtask

    task automatic pulse_start();
        startn = 1'b0;
        tick();
        startn = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int budget, output int n);
        n = 0;
        while (mag_on === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, ".mag_off"}, mag_on, 0);
    endtask

    task automatic check_model();
        chk("rnd.ones", sec_ones_seg, seg_exp(m_sec % 10));
        chk("rnd.tens", sec_tens_seg, seg_exp(m_sec / 10));
        chk("rnd.mins", mins_seg, mins_exp(m_mins));
        chk("rnd.mag", mag_on, m_cook);
    endtask

    initial begin
        int n;
        int r;
        reset = 1'b1; keypad = '0; startn = 1'b1; stopn = 1'b1;
        clearn = 1'b1; door_closed = 1'b1; lockstep = 0;
        repeat (2) tick();
        chk_time("reset", 0, 0, 0);
        chk("reset.mag", mag_on, 0);
        reset = 1'b0;
        tick();

        // Entry 3,5,9 with long holds
        press(3, 11);
        chk_time("hold3", 0, 0, 3);
        press(5, 11);
        press(9, 11);
        chk_time("t1", 3, 5, 9);
        chk("t1.mag", mag_on, 0);

        // Start with door open is ignored
        door_closed = 1'b0;
        pulse_start();
        repeat (3) tick();
        chk("t2.door_open_mag", mag_on, 0);
        chk_time("t2.door_open", 3, 5, 9);
        door_closed = 1'b1;
        tick();
        pulse_start();
        chk("t2.mag_on", mag_on, 1);
        repeat (TPS - 1) tick();
        chk_time("t2.pre_tick", 3, 5, 9);
        tick();
        chk_time("t2.first_tick", 3, 5, 8);
        wait_done("t2", 239 * TPS, n);
        chk("t2.len", n, 238 * TPS);
        chk_time("t2.end", 0, 0, 0);

        // Door opened mid-cook pauses, resume finishes
        press(2, 3); press(4, 3); press(5, 3);
        chk_time("t3.entry", 2, 4, 5);
        pulse_start();
        repeat (30 * TPS) tick();
        door_closed = 1'b0;
        tick();
        chk("t3.paused_mag", mag_on, 0);
        chk_time("t3.paused", 2, 1, 5);
        repeat (50) tick();
        chk_time("t3.held", 2, 1, 5);
        door_closed = 1'b1;
        tick();
        pulse_start();
        chk("t3.resume_mag", mag_on, 1);
        wait_done("t3", 136 * TPS, n);
        chk("t3.len", n, 135 * TPS);
        chk_time("t3.end", 0, 0, 0);

        // Stop pauses, restart finishes
        press(4, 3); press(4, 3); press(5, 3);
        pulse_start();
        repeat (30 * TPS) tick();
        stopn = 1'b0;
        tick();
        stopn = 1'b1;
        chk("t4.paused_mag", mag_on, 0);
        chk_time("t4.paused", 4, 1, 5);
        repeat (20) tick();
        chk_time("t4.held", 4, 1, 5);
        pulse_start();
        chk("t4.resume_mag", mag_on, 1);
        wait_done("t4", 256 * TPS, n);
        chk("t4.len", n, 255 * TPS);
        chk_time("t4.end", 0, 0, 0);

        // Clear mid-cook, later start ignored
        press(2, 3); press(3, 3); press(5, 3);
        pulse_start();
        repeat (30 * TPS) tick();
        chk_time("t5.running", 2, 0, 5);
        clearn = 1'b0;
        tick();
        clearn = 1'b1;
        chk_time("t5.cleared", 0, 0, 0);
        chk("t5.cleared_mag", mag_on, 0);
        pulse_start();
        repeat (5) tick();
        chk("t5.start_ignored", mag_on, 0);

        // 1:00 -> 0:59, then reset during cook
        press(1, 3); press(0, 3); press(0, 3);
        chk_time("b.entry", 1, 0, 0);
        pulse_start();
        repeat (TPS) tick();
        chk_time("b.borrow", 0, 5, 9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_time("b.reset", 0, 0, 0);
        chk("b.reset_mag", mag_on, 0);
        tick();

        // Four keys, non-one-hot, key during cook
        press(1, 3); press(2, 3); press(3, 3); press(4, 3);
        chk_time("b.four", 2, 3, 4);
        keypad = 10'b0000000011;
        repeat (5) tick();
        keypad = '0;
        repeat (2) tick();
        chk_time("b.multi", 2, 3, 4);
        pulse_start();
        repeat (5) tick();
        press(7, 3);
        chk_time("b.key_in_cook", 2, 3, 4);
        chk("b.key_in_cook_mag", mag_on, 1);
        clearn = 1'b0;
        tick();
        clearn = 1'b1;

        // Randomized phase against the model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        lockstep = 1;
        for (int c = 0; c < 5000; c++) begin
            r = $urandom_range(0, 999);
            if (r < 80)       keypad = 10'd1 << $urandom_range(0, 9);
            else if (r < 100) keypad = 10'($urandom);
            else if (r >= 500) keypad = '0;
            startn = ($urandom_range(0, 99) < 4) ? 1'b0 : 1'b1;
            stopn  = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            clearn = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 999) < 5) door_closed = ~door_closed;
            tick();
            check_model();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
